// File: rtl/shift_reg_checker_pkg.sv
// Shared encodings for the shift-register checker: mode, enable level and checker state.
// Imported by the checker top and by its reference-model sub-module.
package shift_reg_checker_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT     = 2'b00,
    MODE_ROTATE    = 2'b01,
    MODE_PARA_LOAD = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'b00,
    ST_CHECK = 2'b01,
    ST_FAIL  = 2'b10
  } state_e;

  localparam logic ENABLE    = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_reg_model.sv
// Reference model (MQ, and MS when CHK_SOUT_EN is defined) of the 4-bit shift register.
// Updates one edge after the observed controls; no backpressure, upd gates every change.
module shift_reg_model
  import shift_reg_checker_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic       enb,
  input  logic       dir,
  input  logic       s_in,
  input  mode_e      modo,
  input  logic [3:0] d,
`ifdef CHK_SOUT_EN
  output logic       ms,
`endif
  output logic [3:0] mq
);

  logic [3:0] mq_nxt;
`ifdef CHK_SOUT_EN
  logic       ms_nxt;
`endif

  always_comb begin
    mq_nxt = mq;
    unique case (modo)
      MODE_SHIFT:     mq_nxt = (dir == DIR_RIGHT) ? {s_in, mq[3:1]} : {mq[2:0], s_in};
      MODE_ROTATE:    mq_nxt = (dir == DIR_RIGHT) ? {mq[0], mq[3:1]} : {mq[2:0], mq[3]};
      MODE_PARA_LOAD: mq_nxt = d;
      default:        mq_nxt = mq;
    endcase
  end

`ifdef CHK_SOUT_EN
  // Serial output only carries the bit shifted out; rotate and load clear it.
  always_comb begin
    ms_nxt = ms;
    unique case (modo)
      MODE_SHIFT:     ms_nxt = (dir == DIR_RIGHT) ? mq[0] : mq[3];
      MODE_ROTATE:    ms_nxt = 1'b0;
      MODE_PARA_LOAD: ms_nxt = 1'b0;
      default:        ms_nxt = ms;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ms <= 1'b0;
    end else if (upd && (enb == ENABLE)) begin
      ms <= ms_nxt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mq <= 4'b0000;
    end else if (upd && (enb == ENABLE)) begin
      mq <= mq_nxt;
    end
  end

endmodule

// File: rtl/shift_reg_checker.sv
// On-line checker for a 4-bit shift register; S_OUT is compared only when CHK_SOUT_EN is defined.
// ERR pulses the cycle after the edge that samples a diverged Q; no backpressure, purely observing.
module shift_reg_checker
  import shift_reg_checker_pkg::*;
#(
  parameter int ERR_CNT_W = 8,
  parameter int CHK_CNT_W = 16,
  parameter int ERR_LIMIT = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENB,
  input  logic                 DIR,
  input  logic                 S_IN,
  input  logic [1:0]           MODO,
  input  logic [3:0]           D,
  input  logic [3:0]           Q,
  input  logic                 S_OUT,
  output logic                 ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic [CHK_CNT_W-1:0] CHK_CNT,
  output logic [1:0]           STATE
);

  localparam logic [ERR_CNT_W:0] LIMIT_EXT = (ERR_CNT_W + 1)'(ERR_LIMIT);

  state_e               state;
  mode_e                mode;
  logic [3:0]           mq;
  logic                 mismatch;
  logic                 sync_load;
  logic                 model_upd;
  logic [ERR_CNT_W-1:0] err_cnt_nxt;

  assign mode      = mode_e'(MODO);
  assign sync_load = (state == ST_SYNC) && (ENB == ENABLE) && (mode == MODE_PARA_LOAD);
  // Model advances after the comparison on the same edge, so a reload never masks a check.
  assign model_upd = sync_load || (state == ST_CHECK);

`ifdef CHK_SOUT_EN
  logic ms;
  assign mismatch = (Q != mq) || (S_OUT != ms);
`else
  logic unused_sout;
  assign unused_sout = S_OUT;
  assign mismatch    = (Q != mq);
`endif

  shift_reg_model u_model (
    .clk  (CLK),
    .rst  (RST),
    .upd  (model_upd),
    .enb  (ENB),
    .dir  (DIR),
    .s_in (S_IN),
    .modo (mode),
    .d    (D),
`ifdef CHK_SOUT_EN
    .ms   (ms),
`endif
    .mq   (mq)
  );

  assign err_cnt_nxt = (ERR_CNT == '1) ? ERR_CNT : ERR_CNT + 1'b1;
  assign STATE       = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_SYNC;
      ERR     <= 1'b0;
      ERR_CNT <= '0;
      CHK_CNT <= '0;
    end else begin
      ERR <= 1'b0;
      unique case (state)
        ST_SYNC: begin
          if (sync_load) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (CHK_CNT != '1) CHK_CNT <= CHK_CNT + 1'b1;
          if (mismatch) begin
            ERR     <= 1'b1;
            ERR_CNT <= err_cnt_nxt;
            if ({1'b0, err_cnt_nxt} >= LIMIT_EXT) state <= ST_FAIL;
          end
        end
        default: begin
          state <= ST_FAIL;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_reg_checker.md
SHIFT_REG_CHECKER -- requirements
Module: shift_reg_checker

Interface
REQ-001 Parameter ERR_CNT_W, default 8, width of the saturating mismatch counter.
REQ-002 Parameter CHK_CNT_W, default 16, width of the saturating comparison counter.
REQ-003 Parameter ERR_LIMIT, default 4, mismatch count at which the block enters FAIL.
REQ-004 CLK  input  1  single clock; all sampling and updates on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 ENB  input  1  observed enable to the 4-bit shift register; 1 = enabled.
REQ-007 DIR  input  1  observed direction; 0 = left, 1 = right.
REQ-008 S_IN  input  1  observed serial input.
REQ-009 MODO  input  2  observed mode: 00 SHIFT, 01 ROTATE, 10 PARA_LOAD, 11 HOLD.
REQ-010 D  input  4  observed parallel-load data.
REQ-011 Q  input  4  register output under check.
REQ-012 S_OUT  input  1  serial output under check.
REQ-013 ERR  output  1  one-cycle pulse per detected mismatch.
REQ-014 ERR_CNT  output  ERR_CNT_W  saturating mismatch count.
REQ-015 CHK_CNT  output  CHK_CNT_W  saturating count of comparisons performed.
REQ-016 STATE  output  2  FSM state: 00 SYNC, 01 CHECK, 10 FAIL.

Function
REQ-017 The block shall hold a 4-bit model register MQ and a 1-bit model MS of the expected Q and S_OUT.
REQ-018 On each rising edge with ENB=1, model update: SHIFT/DIR=0: MQ<={MQ[2:0],S_IN}, MS<=MQ[3]; SHIFT/DIR=1: MQ<={S_IN,MQ[3:1]}, MS<=MQ[0].
REQ-019 ROTATE/DIR=0: MQ<={MQ[2:0],MQ[3]}; ROTATE/DIR=1: MQ<={MQ[0],MQ[3:1]}; MS<=0.
REQ-020 PARA_LOAD: MQ<=D, MS<=0; HOLD: MQ, MS unchanged.
REQ-021 With ENB=0, MQ and MS shall hold regardless of MODO.
REQ-022 In SYNC, no comparison occurs; the first edge with ENB=1 and MODO=PARA_LOAD loads the model and moves to CHECK.
REQ-023 In CHECK, at every rising edge the sampled Q (and S_OUT per REQ-034) shall be compared with MQ/MS, and the model shall then update per REQ-018..021.
REQ-024 Latency: a DUT divergence caused at edge k shall assert ERR in the cycle after edge k+1.
REQ-025 Each comparison in CHECK shall increment CHK_CNT; each mismatch shall increment ERR_CNT and pulse ERR.
REQ-026 Both counters shall saturate at all-ones without wrap-around.
REQ-027 CHECK shall go to FAIL on the edge where ERR_CNT reaches ERR_LIMIT; FAIL is sticky until RST.
REQ-028 In FAIL, counters and model freeze and ERR stays 0.
REQ-029 A PARA_LOAD in CHECK shall not bypass the comparison on that edge; comparison precedes reload.

Reset
REQ-030 With RST=1 at a rising edge: STATE=SYNC, MQ=0, MS=0, ERR=0, ERR_CNT=0, CHK_CNT=0.
REQ-031 RST takes priority over all other inputs, including mid-operation in CHECK or FAIL.
REQ-032 No comparison, model update or counting occurs on an edge where RST=1.

Configuration
REQ-033 Macro CHK_SOUT_EN selects S_OUT checking.
REQ-034 With CHK_SOUT_EN defined, a mismatch is Q!=MQ or S_OUT!=MS; without it, only Q!=MQ, MS logic is removed and S_OUT is unused.

Structure
REQ-035 A shared package shall hold the MODO encodings (SHIFT, ROTATE, PARA_LOAD, HOLD), ENABLE level, and the STATE encodings.
REQ-036 The model (REQ-017..021) shall be a sub-module shift_reg_model; the FSM, comparison and counters stay in the top.

Verification
REQ-037 Reset, then PARA_LOAD D=4'b0010, HOLD 3 cycles with correct DUT -> STATE=CHECK, ERR_CNT=0, CHK_CNT=3.
REQ-038 Load 4'b1001, SHIFT DIR=0 S_IN=1 for 2 edges -> expected Q 4'b0011 then 4'b0111; DUT forced to 4'b0110 on second -> one ERR pulse, ERR_CNT=1.
REQ-039 Load 4'b1000, ROTATE DIR=1 4 edges -> Q sequence 0100,0010,0001,1000 matched, ERR_CNT=0.
REQ-040 ENB=0 with MODO=SHIFT for 5 edges after load 4'b1111 -> model stays 4'b1111; DUT changing Q -> ERR each edge, FAIL after 4th mismatch (ERR_LIMIT=4).
REQ-041 With CHK_SOUT_EN, load 4'b1000, SHIFT DIR=0 -> expected S_OUT=1; DUT S_OUT=0 -> ERR; same stimulus without macro -> no ERR.
REQ-042 RST asserted in FAIL -> next cycle STATE=SYNC, all counters 0; SHIFT edges before a PARA_LOAD produce no comparisons.
